// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU control path.
// CPU_SEQ_STEP_EN adds the S_HOLD single-step state.
package cpu_pkg;

  localparam int DEF_OPC_W   = 3;
  localparam int DEF_RADDR_W = 2;

  localparam logic [1:0] PH_LOAD = 2'b00;
  localparam logic [1:0] PH_EXEC = 2'b01;
  localparam logic [1:0] PH_OUT  = 2'b10;
  localparam logic [1:0] PH_IDLE = 2'b11;

  // Instruction word: [7:5] opcode, [4:3] rd, [2:1] rs, [0] last
  localparam int INST_OPC_LSB = 5;
  localparam int INST_RD_LSB  = 3;
  localparam int INST_RS_LSB  = 1;
  localparam int INST_LAST    = 0;

  typedef struct packed {
    logic [2:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       last;
  } inst_t;

`ifdef CPU_SEQ_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_OUT, S_HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_OUT
  } state_t;
`endif

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S_IDLE:           phase_of = PH_IDLE;
      S_FETCH, S_DECODE: phase_of = PH_LOAD;
      S_OUT:            phase_of = PH_OUT;
      default:          phase_of = PH_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/cpu_seq_wait_ctr.sv
// Loadable down-counter timing the ALU latency; at_one marks the final wait cycle.
module cpu_seq_wait_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         at_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end

  assign at_one = (cnt == W'(1));

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/write-back sequencer for the 8-bit CPU.
// Optional single-step mode via `define CPU_SEQ_STEP_EN (adds step port, S_HOLD).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 4,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef CPU_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic [7:0]         inst_data,
  output logic               inst_rd_en,
  output logic [PC_W-1:0]    inst_addr,
  output logic [RADDR_W-1:0] op_addr_1,
  output logic [RADDR_W-1:0] op_addr_2,
  output logic               alu_en,
  output logic [OPC_W-1:0]   opcode,
  output logic               reg_wr_en,
  output logic [RADDR_W-1:0] reg_addr,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q;
  inst_t           inst_q;
  logic            ctr_load, ctr_dec, ctr_at_one;
  logic            run_end;

  // End of memory is treated as an implicit last so pc never wraps.
  assign run_end = inst_q.last || (pc_q == {PC_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start)       pc_q <= '0;
      else if (state_q == S_WB && !run_end) pc_q <= pc_q + PC_W'(1);
      if (state_q == S_DECODE)              inst_q <= inst_t'(inst_data);
    end
  end

  always_comb begin
    state_d    = state_q;
    inst_rd_en = 1'b0;
    alu_en     = 1'b0;
    reg_wr_en  = 1'b0;
    done       = 1'b0;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        inst_rd_en = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        alu_en   = 1'b1;
        ctr_load = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        ctr_dec = 1'b1;
        if (ctr_at_one) state_d = S_WB;
      end
      S_WB: begin
        reg_wr_en = 1'b1;
`ifdef CPU_SEQ_STEP_EN
        state_d   = run_end ? S_OUT : S_HOLD;
`else
        state_d   = run_end ? S_OUT : S_FETCH;
`endif
      end
      S_OUT: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
`ifdef CPU_SEQ_STEP_EN
      S_HOLD:   if (step) state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  cpu_seq_wait_ctr #(.W(3)) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (3'(ALU_LAT)),
    .dec      (ctr_dec),
    .at_one   (ctr_at_one)
  );

  assign inst_addr = pc_q;
  assign op_addr_1 = RADDR_W'(inst_q.rd);
  assign op_addr_2 = RADDR_W'(inst_q.rs);
  assign reg_addr  = RADDR_W'(inst_q.rd);
  assign opcode    = OPC_W'(inst_q.opc);
  assign phase     = phase_of(state_q);
  assign busy      = (state_q != S_IDLE) && (state_q != S_OUT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a cycle-schedule reference model.
module tb_cpu_sequencer;

  localparam int PC_W  = 2;
  localparam int L     = 2;
  localparam int DEPTH = 4;
  localparam int IC    = 4 + L;
`ifdef CPU_SEQ_STEP_EN
  localparam int STEP_MODE = 1;
`else
  localparam int STEP_MODE = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            step = 1'b0;
  logic [7:0]      inst_data = 8'h00;
  logic            inst_rd_en, alu_en, reg_wr_en, busy, done;
  logic [PC_W-1:0] inst_addr;
  logic [1:0]      op_addr_1, op_addr_2, reg_addr, phase;
  logic [2:0]      opcode;

  logic [7:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int fetch_q[$];
  int wr_cnt = 0;
  int exp_ph[8] = '{0, 0, 1, 1, 1, 1, 2, 3};

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(PC_W), .ALU_LAT(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef CPU_SEQ_STEP_EN
    .step       (step),
`endif
    .inst_data  (inst_data),
    .inst_rd_en (inst_rd_en),
    .inst_addr  (inst_addr),
    .op_addr_1  (op_addr_1),
    .op_addr_2  (op_addr_2),
    .alu_en     (alu_en),
    .opcode     (opcode),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .phase      (phase),
    .busy       (busy),
    .done       (done)
  );

  // Instruction memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (inst_rd_en) inst_data <= mem[inst_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: which instruction is running and how many cycles into it.
  bit m_act = 0, m_out = 0, m_hold = 0;
  int m_idx = 0, m_off = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_act <= 0; m_out <= 0; m_hold <= 0; m_idx <= 0; m_off <= 0;
    end else if (m_out) begin
      m_out <= 0;
    end else if (m_hold) begin
      if (step) begin m_hold <= 0; m_act <= 1; m_off <= 0; end
    end else if (m_act) begin
      if (m_off == IC - 1) begin
        if (mem[m_idx][0] || m_idx == DEPTH - 1) begin
          m_act <= 0; m_out <= 1;
        end else begin
          m_idx <= m_idx + 1;
          m_off <= 0;
          if (STEP_MODE != 0) begin m_act <= 0; m_hold <= 1; end
        end
      end else m_off <= m_off + 1;
    end else if (start) begin
      m_act <= 1; m_idx <= 0; m_off <= 0;
    end
  end

  always @(negedge clk) if (mon_en) begin
    logic [7:0] w;
    int e_ph;
    bit e_rd, e_alu, e_wr, e_busy, e_done;
    w = mem[m_idx];
    e_rd = 0; e_alu = 0; e_wr = 0; e_busy = 0; e_done = 0;
    if (m_out) begin e_ph = 2; e_done = 1; end
    else if (m_hold) begin e_ph = 1; e_busy = 1; end
    else if (m_act) begin
      e_busy = 1;
      e_ph   = (m_off < 2) ? 0 : 1;
      e_rd   = (m_off == 0);
      e_alu  = (m_off == 2);
      e_wr   = (m_off == IC - 1);
    end else e_ph = 3;
    chk("m_phase", int'(phase), e_ph);
    chk("m_busy", int'(busy), int'(e_busy));
    chk("m_done", int'(done), int'(e_done));
    chk("m_inst_rd_en", int'(inst_rd_en), int'(e_rd));
    chk("m_alu_en", int'(alu_en), int'(e_alu));
    chk("m_reg_wr_en", int'(reg_wr_en), int'(e_wr));
    if (e_rd) chk("m_inst_addr", int'(inst_addr), m_idx);
    if (m_act && m_off >= 2) begin
      chk("m_opcode", int'(opcode), int'(w[7:5]));
      chk("m_op_addr_1", int'(op_addr_1), int'(w[4:3]));
      chk("m_op_addr_2", int'(op_addr_2), int'(w[2:1]));
    end
    if (e_wr) chk("m_reg_addr", int'(reg_addr), int'(w[4:3]));
    chk("one_strobe", int'((int'(inst_rd_en) + int'(alu_en) + int'(reg_wr_en)) <= 1), 1);
    if (inst_rd_en) fetch_q.push_back(int'(inst_addr));
    if (reg_wr_en) wr_cnt++;
  end

  task automatic advance(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Leaves the bench one cycle after start was sampled (the first fetch cycle).
  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin advance(1); n++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    step = (STEP_MODE != 0);

    // Power-on reset
    repeat (3) @(negedge clk);
    #1 mon_en = 1'b1;
    chk("rst_phase", int'(phase), 3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes", int'({inst_rd_en, alu_en, reg_wr_en}), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;
    advance(1);

    // Single instruction with literal cycle timing
    mem[0] = 8'b011_01_10_1;
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("s1_phase_c%0d", c), int'(phase), exp_ph[c-1]);
      chk($sformatf("s1_rd_c%0d", c), int'(inst_rd_en), int'(c == 1));
      chk($sformatf("s1_alu_c%0d", c), int'(alu_en), int'(c == 3));
      chk($sformatf("s1_wr_c%0d", c), int'(reg_wr_en), int'(c == 6));
      chk($sformatf("s1_done_c%0d", c), int'(done), int'(c == 7));
      if (c == 3) begin
        chk("s1_opcode", int'(opcode), 3);
        chk("s1_op1", int'(op_addr_1), 1);
        chk("s1_op2", int'(op_addr_2), 2);
      end
      if (c == 6) chk("s1_reg_addr", int'(reg_addr), 1);
      advance(1);
    end

    // Reset during S_WAIT
    pulse_start();
    advance(3);
    chk("rw_in_wait", int'(phase), 1);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      advance(1);
      chk("rw_phase", int'(phase), 3);
      chk("rw_busy", int'(busy), 0);
      chk("rw_strobes", int'({inst_rd_en, alu_en, reg_wr_en}), 0);
    end
    rst = 1'b1;
    advance(1);
    chk("rw_no_wr_after", int'(reg_wr_en), 0);
    pulse_start();
    chk("rw_restart_rd", int'(inst_rd_en), 1);
    chk("rw_restart_addr", int'(inst_addr), 0);
    wait_done(n);
    advance(2);

    // Three instructions, last on mem[2]
    mem[0] = 8'b000_00_01_0;
    mem[1] = 8'b101_10_11_0;
    mem[2] = 8'b110_11_00_1;
    mem[3] = 8'b111_01_01_0;
    fetch_q.delete(); wr_cnt = 0;
    pulse_start();
    wait_done(n);
    chk("p3_len", n, 3 * IC + STEP_MODE * 2);
    chk("p3_nfetch", fetch_q.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("p3_fetch%0d", i), fetch_q[i], i);
    chk("p3_nwr", wr_cnt, 3);
    advance(2);

    // No last bit: end of memory terminates the run
    mem[0] = 8'b001_00_01_0;
    mem[1] = 8'b010_01_10_0;
    mem[2] = 8'b100_10_11_0;
    mem[3] = 8'b111_11_00_0;
    fetch_q.delete(); wr_cnt = 0;
    pulse_start();
    wait_done(n);
    chk("p4_len", n, 4 * IC + STEP_MODE * 3);
    chk("p4_nwr", wr_cnt, 4);
    advance(3);
    chk("p4_nfetch", fetch_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("p4_fetch%0d", i), fetch_q[i], i);
    chk("p4_idle", int'(phase), 3);

    // start during S_EXEC and S_OUT is ignored; start in S_IDLE is taken
    mem[0] = 8'b010_11_00_1;
    fetch_q.delete();
    pulse_start();
    advance(2);
    chk("ig_exec", int'(alu_en), 1);
    start = 1'b1;
    advance(1);
    start = 1'b0;
    chk("ig_exec_phase", int'(phase), 1);
    chk("ig_exec_busy", int'(busy), 1);
    advance(3);
    chk("ig_out_done", int'(done), 1);
    start = 1'b1;
    advance(1);
    chk("ig_out_idle", int'(phase), 3);
    advance(1);
    start = 1'b0;
    chk("ig_new_rd", int'(inst_rd_en), 1);
    chk("ig_new_addr", int'(inst_addr), 0);
    wait_done(n);
    chk("ig_nfetch", fetch_q.size(), 2);
    advance(2);

`ifdef CPU_SEQ_STEP_EN
    // Single-step: hold after the first write-back until step
    step = 1'b0;
    mem[0] = 8'b001_01_10_0;
    mem[1] = 8'b011_10_01_1;
    pulse_start();
    advance(5);
    chk("st_wb", int'(reg_wr_en), 1);
    step = 1'b1;
    advance(1);
    step = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("st_hold_phase", int'(phase), 1);
      chk("st_hold_strobes", int'({inst_rd_en, alu_en, reg_wr_en}), 0);
      advance(1);
    end
    step = 1'b1;
    advance(1);
    step = 1'b0;
    chk("st_fetch_rd", int'(inst_rd_en), 1);
    chk("st_fetch_addr", int'(inst_addr), 1);
    wait_done(n);
    advance(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Control stage directly upstream of the ALU and register file in the 8-bit CPU.
- Fetches 8-bit instruction words from instruction memory, decodes them, and drives operand addresses and opcode to the ALU. It times the ALU result, then issues the register write-back.
- Generates the 2-bit phase code consumed by the top level: 00 load, 01 execute, 10 output, 11 idle.

Parameters:
- PC_W, 4, program counter width; instruction memory depth is 2**PC_W.
- RADDR_W, 2, register address width (4 registers).
- OPC_W, 3, ALU opcode width.
- ALU_LAT, 1, cycles from alu_en to valid ALU result; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start  in  1  one-cycle pulse; begins a program run from pc 0
- inst_data  in  8  instruction word; valid the cycle after inst_rd_en
- inst_rd_en  out  1  instruction memory read strobe
- inst_addr  out  PC_W  instruction memory address (= pc)
- op_addr_1  out  RADDR_W  ALU operand 1 register address (rd)
- op_addr_2  out  RADDR_W  ALU operand 2 register address (rs)
- alu_en  out  1  one-cycle ALU enable
- opcode  out  OPC_W  ALU opcode
- reg_wr_en  out  1  one-cycle register write strobe; stores the ALU result
- reg_addr  out  RADDR_W  write-back register address
- phase  out  2  phase code (PC_Inst encoding)
- busy  out  1  high from the first cycle after an accepted start until the OUT state
- done  out  1  one-cycle pulse in the OUT state

Behaviour:
- Instruction format: [7:5] opcode, [4:3] rd, [2:1] rs, [0] last.
- Semantics: rd <= rd op rs. When last=1, the run ends after that instruction's write-back.
- FSM states: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_OUT.
- Phase mapping:
  - S_IDLE -> 11
  - S_FETCH and S_DECODE -> 00
  - S_EXEC, S_WAIT and S_WB -> 01
  - S_OUT -> 10
- Reset (rst=0 at a clk edge):
  - State goes to S_IDLE; pc=0; wait counter=0.
  - All strobes are 0; instruction latch is 0; done=0; busy=0; phase=11.
  - Reset mid-run aborts immediately. No write strobe is issued on the cycle after reset.
- S_IDLE: start=1 -> S_FETCH with pc=0. Otherwise stay.
- S_FETCH: inst_rd_en=1 and inst_addr=pc for one cycle -> S_DECODE.
- S_DECODE: latch inst_data -> S_EXEC.
  - op_addr_1, op_addr_2, opcode and reg_addr are driven from the latch.
  - They remain stable from S_EXEC through S_WB.
- S_EXEC: alu_en=1 for one cycle; wait counter loaded with ALU_LAT -> S_WAIT.
- S_WAIT: the counter decrements each cycle. It exits to S_WB on the cycle it reaches 1, so S_WAIT lasts exactly ALU_LAT cycles.
- S_WB: reg_wr_en=1 for one cycle with reg_addr=rd.
  - If last=1 or pc=2**PC_W-1: next state S_OUT, pc unchanged.
  - Otherwise: pc <= pc+1, next state S_FETCH.
  - pc never wraps silently: the end of memory acts as an implicit last.
- Instruction cost: 4+ALU_LAT cycles.
- S_OUT: done=1, busy=0 for one cycle -> S_IDLE.
- start outside S_IDLE is ignored. It is not queued.
- start and an active rst on the same edge: reset wins.
- At most one of inst_rd_en, alu_en and reg_wr_en is high in any cycle.

Optional Feature:
- Macro CPU_SEQ_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After S_WB of a non-last instruction, the FSM enters S_HOLD (phase 01) instead of S_FETCH. pc is already incremented.
  - S_HOLD waits for step=1, then -> S_FETCH.
  - A step asserted during the S_WB cycle is not counted.
  - Reset from S_HOLD behaves as from any state.
- Undefined: no step port and no S_HOLD state; behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg:
  - Phase code constants PH_LOAD, PH_EXEC, PH_OUT, PH_IDLE.
  - FSM state enum.
  - Instruction field bit positions and a struct/typedef for the decoded instruction word.
  - OPC_W and RADDR_W defaults.
- One natural sub-module: cpu_seq_wait_ctr, a loadable down-counter with a "reaches 1" flag, used for S_WAIT. Everything else stays in cpu_sequencer.

Test Plan:
- Reset behaviour: hold rst=0 for 3 cycles mid-S_WAIT -> phase=11, all strobes 0, busy=0; next start fetches inst_addr=0.
- Single instruction: mem[0]=8'b011_01_10_1, start -> inst_rd_en at cycle 1; alu_en with opcode=3, op_addr_1=1, op_addr_2=2 at cycle 3; reg_wr_en with reg_addr=1 at cycle 3+ALU_LAT+1; done one cycle later; phase sequence 11,00,00,01..,10,11.
- Three-instruction program, last=1 on mem[2] -> inst_addr fetches 0,1,2 only; exactly 3 reg_wr_en pulses; 3×(4+ALU_LAT) cycles from start to done.
- No last bit anywhere with PC_W=2 -> 4 instructions execute; done after pc=3 write-back; no fetch from addr 0 after start.
- start pulsed during S_EXEC and again during S_OUT -> both ignored; start during S_IDLE the next cycle -> new run.
- With CPU_SEQ_STEP_EN: 2-instruction program -> after first write-back phase=01 and FSM holds 10 cycles with no strobes; step pulse -> inst_addr=1 fetched the next cycle.
